// File: rtl/inv_mix_columns_serial.sv
// Byte-serial AES InvMixColumns engine.
//
// Accepts one 4-byte column (s0..s3, row 0 first), accumulating each output
// row on the fly as bytes arrive. Once s3 is in, it emits r0..r3 serially.
// Input and output phases never overlap. With bypass latched on s0, the
// column passes through unchanged (final decrypt round).
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   in_valid        - in_byte carries a valid state byte
//   in_ready        - block accepts a byte this cycle
//   in_byte         - column byte s0..s3
//   bypass          - sampled with s0; 1 = pass the column unchanged
//   out_valid       - out_byte carries a valid result byte
//   out_ready       - downstream accepts out_byte this cycle
//   out_byte        - result byte r0..r3
//   out_last        - high with r3 of every column
//   out_block_last  - high with r3 of the last column of the state
module inv_mix_columns_serial #(
    parameter int unsigned COLS_PER_BLOCK = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    input  logic       bypass,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_last,
    output logic       out_block_last
);

    localparam int unsigned ColW = (COLS_PER_BLOCK > 1) ? $clog2(COLS_PER_BLOCK) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(COLS_PER_BLOCK - 1);

    typedef enum logic {StAcc, StEmit} state_e;

    state_e          state_q;
    logic [1:0]      in_idx_q;
    logic [1:0]      out_idx_q;
    logic [ColW-1:0] col_q;
    logic [7:0]      acc_q [4];
    logic            bypass_q;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] x2, x4, x8;
    logic [7:0] m09, m0b, m0d, m0e;
    logic [7:0] prod [4];
    logic       byp_eff;

    always_comb begin
        x2  = xtime(in_byte);
        x4  = xtime(x2);
        x8  = xtime(x4);
        m09 = x8 ^ in_byte;
        m0b = x8 ^ x2 ^ in_byte;
        m0d = x8 ^ x4 ^ in_byte;
        m0e = x8 ^ x4 ^ x2;
        // Inverse matrix is circulant: M[r][k] depends only on (k - r) mod 4.
        for (int r = 0; r < 4; r++) begin
            prod[r] = 8'h00;
            unique case (2'(in_idx_q - 2'(r)))
                2'd0: prod[r] = m0e;
                2'd1: prod[r] = m0b;
                2'd2: prod[r] = m0d;
                2'd3: prod[r] = m09;
                default: prod[r] = 8'h00;
            endcase
        end
        // s0 carries its own bypass flag; later bytes use the latched copy.
        byp_eff = (in_idx_q == 2'd0) ? bypass : bypass_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StAcc;
            in_idx_q  <= 2'd0;
            out_idx_q <= 2'd0;
            col_q     <= '0;
            bypass_q  <= 1'b0;
            for (int r = 0; r < 4; r++) acc_q[r] <= 8'h00;
        end else begin
            unique case (state_q)
                StAcc: begin
                    if (in_valid) begin
                        if (in_idx_q == 2'd0) bypass_q <= bypass;
                        for (int r = 0; r < 4; r++) begin
                            if (byp_eff) begin
                                if (in_idx_q == 2'(r)) acc_q[r] <= in_byte;
                            end else if (in_idx_q == 2'd0) begin
                                acc_q[r] <= prod[r];
                            end else begin
                                acc_q[r] <= acc_q[r] ^ prod[r];
                            end
                        end
                        in_idx_q <= in_idx_q + 2'd1;
                        if (in_idx_q == 2'd3) begin
                            state_q   <= StEmit;
                            out_idx_q <= 2'd0;
                        end
                    end
                end
                StEmit: begin
                    if (out_ready) begin
                        out_idx_q <= out_idx_q + 2'd1;
                        if (out_idx_q == 2'd3) begin
                            state_q <= StAcc;
                            col_q   <= (col_q == ColLast) ? '0 : col_q + ColW'(1);
                        end
                    end
                end
                default: state_q <= StAcc;
            endcase
        end
    end

    assign in_ready       = (state_q == StAcc);
    assign out_valid      = (state_q == StEmit);
    assign out_byte       = out_valid ? acc_q[out_idx_q] : 8'h00;
    assign out_last       = out_valid && (out_idx_q == 2'd3);
    assign out_block_last = out_last && (col_q == ColLast);

endmodule

// File: doc/inv_mix_columns_serial.md
INV_MIX_COLUMNS_SERIAL -- requirements
Module: inv_mix_columns_serial

Interface
REQ-001 Parameter COLS_PER_BLOCK, default 4: number of 4-byte columns per AES state; sets the block counter wrap.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  in_byte holds a valid state byte.
REQ-005 in_ready  output  1  block accepts a byte this cycle.
REQ-006 in_byte  input  8  column byte, order s0,s1,s2,s3 (row 0 first).
REQ-007 bypass  input  1  sampled with s0 of each column; 1 = pass the column unchanged (final decrypt round).
REQ-008 out_valid  output  1  out_byte holds a valid result byte.
REQ-009 out_ready  input  1  downstream accepts out_byte this cycle.
REQ-010 out_byte  output  8  result byte, order r0,r1,r2,r3.
REQ-011 out_last  output  1  high with r3 of every column.
REQ-012 out_block_last  output  1  high with r3 of column COLS_PER_BLOCK-1 of the state.

Function
REQ-013 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-014 FSM states: ACC (in_ready=1, out_valid=0) and EMIT (in_ready=0, out_valid=1); no other states.
REQ-015 ACC: a 2-bit input index counts accepted bytes 0..3; on acceptance of byte 3 the FSM enters EMIT on the next edge.
REQ-016 EMIT: a 2-bit output index selects acc[idx] onto out_byte; it advances per output transfer; after transfer of r3 the FSM returns to ACC on the next edge.
REQ-017 Arithmetic: acc_r = XOR over k of M[r][k]*s_k in GF(2^8), reduction polynomial 0x11B; M rows {0e,0b,0d,09}, {09,0e,0b,0d}, {0d,09,0e,0b}, {0b,0d,09,0e}.
REQ-018 Multiplies by 09/0b/0d/0e are built from xtime chains (x2, x4, x8 with conditional ^0x1B) and XOR; no general multiplier, no lookup tables.
REQ-019 On acceptance of s0, each acc_r is overwritten with M[r][0]*s0 (no separate clear cycle); for s1..s3, acc_r ^= M[r][k]*s_k.
REQ-020 With latched bypass=1, acc_r is loaded with s_r unchanged; bypass is ignored on s1..s3.
REQ-021 Latency: out_valid rises the cycle after s3 is accepted; with out_ready held high, r0..r3 appear on 4 consecutive cycles; in_ready rises the cycle after r3 transfers.
REQ-022 Throughput under no stall: one column per 8 cycles; no input and output overlap.
REQ-023 Backpressure: while out_ready=0 in EMIT, out_byte, out_last, out_block_last and the output index hold stable.
REQ-024 in_valid=0 in ACC inserts bubbles; partial columns are held indefinitely without change.
REQ-025 Column counter 0..COLS_PER_BLOCK-1 increments on r3 transfer and wraps to 0 after the last column; out_block_last = out_last && counter==COLS_PER_BLOCK-1.
REQ-026 in_byte/bypass values while in_ready=0 have no effect.

Reset
REQ-027 rst high at an edge: FSM to ACC, input/output indices and column counter to 0, acc0..acc3 to 0x00, latched bypass to 0.
REQ-028 Reset-state outputs: in_ready=1 (from the first cycle after reset), out_valid=0, out_byte=0x00, out_last=0, out_block_last=0.
REQ-029 Reset mid-column or mid-EMIT discards the partial or pending column; no byte of it is emitted afterwards.
REQ-030 rst has priority over simultaneous input or output transfers in the same cycle.

Verification
REQ-031 Input 8e,4d,a1,bc, bypass=0, out_ready=1 -> outputs db,13,53,45; out_last on 45; out_valid rises one cycle after bc is accepted.
REQ-032 Input 9f,dc,58,9d then d5,d5,d7,d6 -> f2,0a,22,5c then d4,d4,d4,d5; 01,01,01,01 -> 01,01,01,01.
REQ-033 Input 8e,4d,a1,bc with bypass=1 on s0 -> 8e,4d,a1,bc; bypass toggled on s1..s3 has no effect.
REQ-034 Hold out_ready=0 for 5 cycles after out_valid rises -> out_byte holds db, in_ready stays 0, then db,13,53,45 emit in order.
REQ-035 4 columns back-to-back -> out_block_last exactly on the 16th output byte, then on the 32nd byte of the next state.
REQ-036 Assert rst after 2 accepted bytes, then send 8e,4d,a1,bc -> outputs db,13,53,45 only; all outputs at reset values the cycle after rst.
